// File: rtl/tw_core_pkg.sv
// tw_core_pkg: shared encodings for the tw_core tiny accumulator core.
//   op_e   - 4-bit instruction opcodes (1010 is deliberately illegal)
//   mode_e - privilege modes; 2'b11 is never entered
package tw_core_pkg;

  typedef enum logic [3:0] {
    OP_ADD_A   = 4'b0000,
    OP_MOV_AB  = 4'b0001,
    OP_IN_A    = 4'b0010,
    OP_MOV_AI  = 4'b0011,
    OP_MOV_BA  = 4'b0100,
    OP_ADD_B   = 4'b0101,
    OP_IN_B    = 4'b0110,
    OP_MOV_BI  = 4'b0111,
    OP_NOP     = 4'b1000,
    OP_OUT_B   = 4'b1001,
    OP_ILL     = 4'b1010,
    OP_OUT_IMM = 4'b1011,
    OP_SWAP    = 4'b1100,
    OP_SYS     = 4'b1101,
    OP_JNC     = 4'b1110,
    OP_JMP     = 4'b1111
  } op_e;

  typedef enum logic [1:0] {
    MODE_USER = 2'b00,
    MODE_PRIV = 2'b01,
    MODE_EXC  = 2'b10
  } mode_e;

endpackage

// File: rtl/tw_core_exec.sv
// tw_core_exec: purely combinational execute stage of tw_core.
// Given the architectural state and the fetched instruction, produces the
// next register banks, pc, mode and out value, plus the exception flag.
// On an exception every next-state output equals the current state except
// mode/pc, which point at {EXC,0}. Interrupts and halting are the top's job.
//   mode/pc/saved_ip      current control state
//   opcode/imm            fetched instruction fields
//   in_val/out_cur        input port value, current out register
//   usr_*/prv_*           current user and priv banks (A, B, C)
//   nxt_*                 next-state values, exc = instruction faults
module tw_core_exec
  import tw_core_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
) (
  input  mode_e             mode,
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W:0]     saved_ip,
  input  op_e               opcode,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] in_val,
  input  logic [DATA_W-1:0] out_cur,
  input  logic [DATA_W-1:0] usr_a,
  input  logic [DATA_W-1:0] usr_b,
  input  logic              usr_c,
  input  logic [DATA_W-1:0] prv_a,
  input  logic [DATA_W-1:0] prv_b,
  input  logic              prv_c,
  output mode_e             nxt_mode,
  output logic [PC_W-1:0]   nxt_pc,
  output logic [DATA_W-1:0] nxt_out,
  output logic [DATA_W-1:0] nxt_usr_a,
  output logic [DATA_W-1:0] nxt_usr_b,
  output logic              nxt_usr_c,
  output logic [DATA_W-1:0] nxt_prv_a,
  output logic [DATA_W-1:0] nxt_prv_b,
  output logic              nxt_prv_c,
  output logic              exc
);

  // imm is widened so jump-target range checks work for any DATA_W/PC_W mix.
  localparam int IW = (DATA_W > PC_W) ? DATA_W : PC_W;

  logic              user_mode;
  logic [DATA_W-1:0] act_a, act_b, new_a, new_b;
  logic              act_c, new_c;
  logic [IW-1:0]     imm_x;
  logic [PC_W-1:0]   tgt;
  logic              tgt_bad, imm_free, seq;
  logic [PC_W:0]     pc_inc;

  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves a
    // value unassigned (which would infer a latch); blocking '=' is correct
    // here because later statements read the values set earlier.
    nxt_mode  = mode;
    nxt_pc    = pc;
    nxt_out   = out_cur;
    nxt_usr_a = usr_a;
    nxt_usr_b = usr_b;
    nxt_usr_c = usr_c;
    nxt_prv_a = prv_a;
    nxt_prv_b = prv_b;
    nxt_prv_c = prv_c;
    exc       = 1'b0;
    seq       = 1'b1;

    user_mode = (mode == MODE_USER);
    act_a     = user_mode ? usr_a : prv_a;
    act_b     = user_mode ? usr_b : prv_b;
    act_c     = user_mode ? usr_c : prv_c;
    new_a     = act_a;
    new_b     = act_b;
    new_c     = 1'b0;     // only ADD leaves a carry behind

    imm_x     = IW'(imm);
    tgt       = imm_x[PC_W-1:0];
    tgt_bad   = (imm_x >> PC_W) != '0;
    pc_inc    = {1'b0, pc} + (PC_W+1)'(1);

    // Only the ??11 immediates, the two ADDs and JNC may carry a nonzero imm.
    imm_free  = (opcode[1:0] == 2'b11) || (opcode == OP_ADD_A) ||
                (opcode == OP_ADD_B)   || (opcode == OP_JNC);
    if ((imm != '0) && !imm_free) exc = 1'b1;

    case (opcode)
      OP_ADD_A:   {new_c, new_a} = {1'b0, act_a} + {1'b0, imm};
      OP_MOV_AB:  new_a = act_b;
      OP_IN_A:    new_a = in_val;
      OP_MOV_AI:  new_a = imm;
      OP_MOV_BA:  new_b = act_a;
      OP_ADD_B:   {new_c, new_b} = {1'b0, act_b} + {1'b0, imm};
      OP_IN_B:    new_b = in_val;
      OP_MOV_BI:  new_b = imm;
      OP_NOP:     ;
      OP_OUT_B:   nxt_out = act_b;
      OP_OUT_IMM: nxt_out = imm;
      OP_SWAP:    if (user_mode) exc = 1'b1;
      OP_SYS: begin
        seq = 1'b0;
        if (user_mode) begin
          nxt_mode = MODE_PRIV;
          nxt_pc   = '0;
        end else if (saved_ip[PC_W]) begin
          exc = 1'b1;   // return address ran past the end of program space
        end else begin
          nxt_mode = MODE_USER;
          nxt_pc   = saved_ip[PC_W-1:0];
        end
      end
      OP_JNC: begin
        if (tgt_bad) exc = 1'b1;
        if (!act_c) begin
          seq    = 1'b0;
          nxt_pc = tgt;
        end
      end
      OP_JMP: begin
        if (tgt_bad) exc = 1'b1;
        seq    = 1'b0;
        nxt_pc = tgt;
      end
      default:    exc = 1'b1;
    endcase

    // Falling off the end of program space faults rather than wrapping.
    if (seq) begin
      if (pc_inc[PC_W]) exc = 1'b1;
      else              nxt_pc = pc_inc[PC_W-1:0];
    end

    if (user_mode) begin
      nxt_usr_a = new_a;
      nxt_usr_b = new_b;
      nxt_usr_c = new_c;
    end else begin
      nxt_prv_a = new_a;
      nxt_prv_b = new_b;
      nxt_prv_c = new_c;
    end

    // SWAP only retires outside USER, so the priv bank is the active one and
    // its C has already been cleared above.
    if (opcode == OP_SWAP) begin
      nxt_usr_a = prv_a;
      nxt_prv_a = usr_a;
    end

    if (exc) begin
      nxt_out   = out_cur;
      nxt_usr_a = usr_a;
      nxt_usr_b = usr_b;
      nxt_usr_c = usr_c;
      nxt_prv_a = prv_a;
      nxt_prv_b = prv_b;
      nxt_prv_c = prv_c;
      nxt_mode  = MODE_EXC;
      nxt_pc    = '0;
    end
  end

endmodule

// File: rtl/tw_core.sv
// tw_core: single-cycle tiny core with user/priv register banks, software
// and hardware interrupts, and double-fault halt.
//   clock   sole clock        reset   synchronous active-high reset
//   addr    {mode, pc} fetch  data    {opcode, imm} for the current addr
//   in      input port        out     registered output port
//   irq     level interrupt   irq_ack one-cycle pulse after interrupt entry
//   halted  stopped after an exception raised in EXC mode
module tw_core
  import tw_core_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int PC_W    = 4,
  parameter int IRQ_VEC = 2 ** (PC_W - 1)
) (
  input  logic              clock,
  input  logic              reset,
  output logic [PC_W+1:0]   addr,
  input  logic [DATA_W+3:0] data,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  input  logic              irq,
  output logic              irq_ack,
  output logic              halted
);

  mode_e             mode_q, mode_d, x_mode;
  logic [PC_W-1:0]   pc_q, pc_d, x_pc;
  logic [PC_W:0]     saved_ip_q, saved_ip_d;
  logic [DATA_W-1:0] out_q, out_d, x_out;
  logic [DATA_W-1:0] usr_a_q, usr_a_d, x_usr_a, usr_b_q, usr_b_d, x_usr_b;
  logic [DATA_W-1:0] prv_a_q, prv_a_d, x_prv_a, prv_b_q, prv_b_d, x_prv_b;
  logic              usr_c_q, usr_c_d, x_usr_c, prv_c_q, prv_c_d, x_prv_c;
  logic              irq_ack_q, irq_ack_d, halted_q, halted_d, x_exc;

  tw_core_exec #(.DATA_W(DATA_W), .PC_W(PC_W)) u_exec (
    .mode      (mode_q),
    .pc        (pc_q),
    .saved_ip  (saved_ip_q),
    .opcode    (op_e'(data[DATA_W+3:DATA_W])),
    .imm       (data[DATA_W-1:0]),
    .in_val    (in),
    .out_cur   (out_q),
    .usr_a     (usr_a_q),
    .usr_b     (usr_b_q),
    .usr_c     (usr_c_q),
    .prv_a     (prv_a_q),
    .prv_b     (prv_b_q),
    .prv_c     (prv_c_q),
    .nxt_mode  (x_mode),
    .nxt_pc    (x_pc),
    .nxt_out   (x_out),
    .nxt_usr_a (x_usr_a),
    .nxt_usr_b (x_usr_b),
    .nxt_usr_c (x_usr_c),
    .nxt_prv_a (x_prv_a),
    .nxt_prv_b (x_prv_b),
    .nxt_prv_c (x_prv_c),
    .exc       (x_exc)
  );

  // Priority below reset: halted > exception > interrupt > normal retire.
  always_comb begin
    mode_d     = mode_q;
    pc_d       = pc_q;
    saved_ip_d = saved_ip_q;
    out_d      = out_q;
    usr_a_d    = usr_a_q;
    usr_b_d    = usr_b_q;
    usr_c_d    = usr_c_q;
    prv_a_d    = prv_a_q;
    prv_b_d    = prv_b_q;
    prv_c_d    = prv_c_q;
    halted_d   = halted_q;
    irq_ack_d  = 1'b0;

    if (!halted_q) begin
      if (x_exc) begin
        if (mode_q == MODE_EXC) begin
          halted_d = 1'b1;         // double fault: freeze everything
        end else begin
          mode_d = x_mode;
          pc_d   = x_pc;
        end
      end else if (irq && (mode_q == MODE_USER)) begin
        // The interrupted instruction is abandoned and re-fetched on IRET.
        saved_ip_d = {1'b0, pc_q};
        mode_d     = MODE_PRIV;
        pc_d       = PC_W'(IRQ_VEC);
        irq_ack_d  = 1'b1;
      end else begin
        mode_d  = x_mode;
        pc_d    = x_pc;
        out_d   = x_out;
        usr_a_d = x_usr_a;
        usr_b_d = x_usr_b;
        usr_c_d = x_usr_c;
        prv_a_d = x_prv_a;
        prv_b_d = x_prv_b;
        prv_c_d = x_prv_c;
        if (mode_q == MODE_USER) saved_ip_d = {1'b0, pc_q} + (PC_W+1)'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values; all architectural state is reset, including both banks.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q     <= MODE_USER;
      pc_q       <= '0;
      saved_ip_q <= '0;
      out_q      <= '0;
      usr_a_q    <= '0;
      usr_b_q    <= '0;
      usr_c_q    <= 1'b0;
      prv_a_q    <= '0;
      prv_b_q    <= '0;
      prv_c_q    <= 1'b0;
      irq_ack_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      pc_q       <= pc_d;
      saved_ip_q <= saved_ip_d;
      out_q      <= out_d;
      usr_a_q    <= usr_a_d;
      usr_b_q    <= usr_b_d;
      usr_c_q    <= usr_c_d;
      prv_a_q    <= prv_a_d;
      prv_b_q    <= prv_b_d;
      prv_c_q    <= prv_c_d;
      irq_ack_q  <= irq_ack_d;
      halted_q   <= halted_d;
    end
  end

  assign addr    = {mode_q, pc_q};
  assign out     = out_q;
  assign irq_ack = irq_ack_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_tw_core.sv
// tb_tw_core: directed scenarios followed by random instruction streams,
// every cycle compared against a behavioural model of the core.
module tb_tw_core;

  localparam int DW   = 4;
  localparam int PW   = 4;
  localparam int IRQV = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [PW+1:0] addr;
  logic [DW+3:0] data;
  logic [DW-1:0] in_p, out_p;
  logic          irq, irq_ack, halted;

  always #5 clock = ~clock;

  tw_core #(.DATA_W(DW), .PC_W(PW), .IRQ_VEC(IRQV)) dut (
    .clock   (clock),
    .reset   (reset),
    .addr    (addr),
    .data    (data),
    .in      (in_p),
    .out     (out_p),
    .irq     (irq),
    .irq_ack (irq_ack),
    .halted  (halted)
  );

  // Behavioural model: bank 0 = user, bank 1 = priv; mode 0/1/2 = USER/PRIV/EXC.
  int m_a[2], m_b[2], m_c[2];
  int m_mode, m_pc, m_sip, m_out, m_ack, m_halt;
  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(int op, int imm, bit irq_v, int in_v, bit rst);
    int  bk, s, t, nxt_pc, nxt_mode;
    bit  exc, jump;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_a[i] = 0; m_b[i] = 0; m_c[i] = 0;
      end
      m_mode = 0; m_pc = 0; m_sip = 0; m_out = 0; m_ack = 0; m_halt = 0;
      return;
    end
    m_ack = 0;
    if (m_halt) return;
    bk  = (m_mode == 0) ? 0 : 1;
    exc = (op == 10);
    if (imm != 0 && !((op % 4) == 3 || op == 0 || op == 5 || op == 14)) exc = 1;
    if ((op == 14 || op == 15) && imm >= (1 << PW)) exc = 1;
    if (op == 12 && m_mode == 0) exc = 1;
    if (op == 13 && m_mode != 0 && m_sip >= (1 << PW)) exc = 1;
    jump = (op == 15) || (op == 13) || (op == 14 && m_c[bk] == 0);
    if (!jump && m_pc + 1 >= (1 << PW)) exc = 1;
    if (exc) begin
      if (m_mode == 2) m_halt = 1;
      else begin m_mode = 2; m_pc = 0; end
      return;
    end
    if (irq_v && m_mode == 0) begin
      m_sip = m_pc; m_mode = 1; m_pc = IRQV; m_ack = 1;
      return;
    end
    nxt_pc   = jump ? imm : m_pc + 1;
    nxt_mode = m_mode;
    if (op == 13) begin
      if (m_mode == 0) begin nxt_mode = 1; nxt_pc = 0; end
      else             begin nxt_mode = 0; nxt_pc = m_sip; end
    end
    m_c[bk] = 0;
    case (op)
      0:  begin s = m_a[bk] + imm; m_a[bk] = s % (1 << DW); m_c[bk] = s / (1 << DW); end
      1:  m_a[bk] = m_b[bk];
      2:  m_a[bk] = in_v;
      3:  m_a[bk] = imm;
      4:  m_b[bk] = m_a[bk];
      5:  begin s = m_b[bk] + imm; m_b[bk] = s % (1 << DW); m_c[bk] = s / (1 << DW); end
      6:  m_b[bk] = in_v;
      7:  m_b[bk] = imm;
      9:  m_out = m_b[bk];
      11: m_out = imm;
      12: begin t = m_a[0]; m_a[0] = m_a[1]; m_a[1] = t; end
      default: ;
    endcase
    if (m_mode == 0) m_sip = m_pc + 1;
    m_pc   = nxt_pc;
    m_mode = nxt_mode;
  endtask

  // Drive one instruction, advance one clock, compare all outputs to the model.
  task automatic step(string tag, int op, int imm, bit irq_v, int in_v, bit rst);
    data  = {op[3:0], imm[DW-1:0]};
    in_p  = in_v[DW-1:0];
    irq   = irq_v;
    reset = rst;
    model(op, imm, irq_v, in_v, rst);
    @(posedge clock);
    #1;
    check({tag, ".addr"},    32'(addr),    32'(m_mode * (1 << PW) + m_pc));
    check({tag, ".out"},     32'(out_p),   32'(m_out));
    check({tag, ".irq_ack"}, 32'(irq_ack), 32'(m_ack));
    check({tag, ".halted"},  32'(halted),  32'(m_halt));
  endtask

  initial begin
    int op, imm, iv, rv;
    bit irq_v, rst;
    irq = 0; in_p = 0; data = 0; reset = 1;

    // Reset state.
    step("rst", 8, 0, 0, 0, 1);
    check("rst_addr", 32'(addr), 32'h00);
    check("rst_out",  32'(out_p), 32'd0);

    // MOV A,9; ADD A,8 -> A=1,C=1; MOV B,A clears C so JNC 0 is taken.
    step("s41_mova", 3, 9, 0, 0, 0);
    step("s41_add",  0, 8, 0, 0, 0);
    step("s41_movb", 4, 0, 0, 0, 0);
    step("s41_jnc0", 14, 0, 0, 0, 0);
    check("s41_jnc_taken", 32'(addr), 32'h00);
    step("s41_outb", 9, 0, 0, 0, 0);
    check("s41_b_is_1", 32'(out_p), 32'd1);
    step("s41_mova2", 3, 9, 0, 0, 0);
    step("s41_add2",  0, 8, 0, 0, 0);
    step("s41_jnc1",  14, 0, 0, 0, 0);
    check("s41_jnc_not_taken", 32'(addr), 32'h04);

    // SWI at pc=5, load priv A, SWAP, IRET -> {USER,6}, user A = 6.
    step("s42_rst", 8, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step("s42_nop", 8, 0, 0, 0, 0);
    step("s42_swi", 13, 0, 0, 0, 0);
    check("s42_swi_addr", 32'(addr), 32'h10);
    step("s42_mova", 3, 6, 0, 0, 0);
    step("s42_swap", 12, 0, 0, 0, 0);
    step("s42_iret", 13, 0, 0, 0, 0);
    check("s42_iret_addr", 32'(addr), 32'h06);
    step("s42_movb", 4, 0, 0, 0, 0);
    step("s42_outb", 9, 0, 0, 0, 0);
    check("s42_user_a", 32'(out_p), 32'd6);

    // Interrupt on OUT imm,7 at pc=3.
    step("s43_rst", 8, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step("s43_nop", 8, 0, 0, 0, 0);
    step("s43_irq", 11, 7, 1, 0, 0);
    check("s43_vec",   32'(addr),    32'h18);
    check("s43_ack",   32'(irq_ack), 32'd1);
    check("s43_out_0", 32'(out_p),   32'd0);
    step("s43_nop", 8, 0, 0, 0, 0);
    check("s43_ack_drop", 32'(irq_ack), 32'd0);
    step("s43_iret", 13, 0, 0, 0, 0);
    check("s43_ret", 32'(addr), 32'h03);
    step("s43_out", 11, 7, 0, 0, 0);
    check("s43_out_7", 32'(out_p), 32'd7);

    // Bad imm in USER -> EXC; illegal opcode in EXC -> halt and freeze.
    step("s44_rst", 8, 0, 0, 0, 1);
    step("s44_out3", 11, 3, 0, 0, 0);
    step("s44_mova", 3, 5, 0, 0, 0);
    step("s44_badimm", 1, 1, 0, 0, 0);
    check("s44_exc", 32'(addr), 32'h20);
    step("s44_ill", 10, 0, 0, 0, 0);
    check("s44_halt", 32'(halted), 32'd1);
    step("s44_frozen", 11, 9, 1, 0, 0);
    check("s44_frozen_addr", 32'(addr), 32'h20);

    // Reset out of halt.
    step("s46_rst", 8, 0, 0, 0, 1);
    check("s46_halt", 32'(halted), 32'd0);
    check("s46_out",  32'(out_p),  32'd0);

    // Fall-through at pc=15, then SWAP in USER.
    for (int i = 0; i < 15; i++) step("s45_nop", 8, 0, 0, 0, 0);
    check("s45_pc15", 32'(addr), 32'h0F);
    step("s45_fall", 8, 0, 0, 0, 0);
    check("s45_fall_exc", 32'(addr), 32'h20);
    step("s45_rst", 8, 0, 0, 0, 1);
    step("s45_swap", 12, 0, 0, 0, 0);
    check("s45_swap_exc", 32'(addr), 32'h20);

    // Random instruction streams; reset whenever the core halts.
    step("rnd_rst", 8, 0, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      op    = $urandom_range(0, 15);
      imm   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0;
      iv    = $urandom_range(0, 15);
      irq_v = ($urandom_range(0, 7) == 0);
      rv    = $urandom_range(0, 199);
      rst   = (m_halt != 0) || (rv == 0);
      step("rnd", op, imm, irq_v, iv, rst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
